// File: rtl/blob_stats_pkg.sv
// -----------------------------------------------------------------------------
// blob_stats_pkg
//   Shared definitions for the blob statistics block: project-wide pixel size,
//   default widths, the controller state encoding and the output record layout
//   (at default widths).
// -----------------------------------------------------------------------------
package blob_stats_pkg;

  // Project-wide labelled-pixel width (mirrors the global pixel size define).
  localparam int PIXEL_SIZE  = 8;

  // Default widths for the blob_stats parameters.
  localparam int LABEL_W_DEF = 8;
  localparam int COORD_W_DEF = 12;
  localparam int CNT_W_DEF   = 20;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,  // zeroing the table, one entry per cycle
    ST_ACCUM = 2'd1,  // accumulating pixels of the current frame
    ST_DUMP  = 2'd2   // streaming non-empty entries out
  } state_e;

  // One output record at default widths.
  typedef struct packed {
    logic [LABEL_W_DEF-1:0] label;
    logic [COORD_W_DEF-1:0] min_x;
    logic [COORD_W_DEF-1:0] max_x;
    logic [COORD_W_DEF-1:0] min_y;
    logic [COORD_W_DEF-1:0] max_y;
    logic [CNT_W_DEF-1:0]   count;
    logic                   last;
  } blob_rec_t;

endpackage

// File: rtl/blob_stats_table.sv
// -----------------------------------------------------------------------------
// blob_stats_table
//   Per-label statistics storage: 2^LABEL_W entries of {count, bbox}.
//   Ports:
//     clk                      clock
//     raddr_i / rd_*_o         combinational read port
//     we_i, waddr_i, wr_*_i    write port (registered on posedge)
//     clr_i, caddr_i           clear port, zeroes one entry; wins over write
// -----------------------------------------------------------------------------
module blob_stats_table
  import blob_stats_pkg::*;
#(
  parameter int LABEL_W = LABEL_W_DEF,
  parameter int COORD_W = COORD_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic [LABEL_W-1:0] raddr_i,
  output logic [CNT_W-1:0]   rd_cnt_o,
  output logic [COORD_W-1:0] rd_min_x_o,
  output logic [COORD_W-1:0] rd_max_x_o,
  output logic [COORD_W-1:0] rd_min_y_o,
  output logic [COORD_W-1:0] rd_max_y_o,
  input  logic               we_i,
  input  logic [LABEL_W-1:0] waddr_i,
  input  logic [CNT_W-1:0]   wr_cnt_i,
  input  logic [COORD_W-1:0] wr_min_x_i,
  input  logic [COORD_W-1:0] wr_max_x_i,
  input  logic [COORD_W-1:0] wr_min_y_i,
  input  logic [COORD_W-1:0] wr_max_y_i,
  input  logic               clr_i,
  input  logic [LABEL_W-1:0] caddr_i
);

  localparam int DEPTH = 1 << LABEL_W;

  logic [CNT_W-1:0]   cnt_q   [DEPTH];
  logic [COORD_W-1:0] min_x_q [DEPTH];
  logic [COORD_W-1:0] max_x_q [DEPTH];
  logic [COORD_W-1:0] min_y_q [DEPTH];
  logic [COORD_W-1:0] max_y_q [DEPTH];

  // Combinational read: a write on one edge is visible to the next cycle's
  // read, so consecutive pixels of one label never see a stale entry.
  assign rd_cnt_o   = cnt_q[raddr_i];
  assign rd_min_x_o = min_x_q[raddr_i];
  assign rd_max_x_o = max_x_q[raddr_i];
  assign rd_min_y_o = min_y_q[raddr_i];
  assign rd_max_y_o = max_y_q[raddr_i];

  // NOTE: the array has no reset; the controller sweeps it through the clear
  // port after every reset, which keeps this a plain register file.
  always_ff @(posedge clk) begin
    if (clr_i) begin
      cnt_q[caddr_i]   <= '0;
      min_x_q[caddr_i] <= '0;
      max_x_q[caddr_i] <= '0;
      min_y_q[caddr_i] <= '0;
      max_y_q[caddr_i] <= '0;
    end else if (we_i) begin
      cnt_q[waddr_i]   <= wr_cnt_i;
      min_x_q[waddr_i] <= wr_min_x_i;
      max_x_q[waddr_i] <= wr_max_x_i;
      min_y_q[waddr_i] <= wr_min_y_i;
      max_y_q[waddr_i] <= wr_max_y_i;
    end
  end

endmodule

// File: rtl/blob_stats.sv
// -----------------------------------------------------------------------------
// blob_stats
//   Accumulates per-label pixel count and bounding box over a frame of
//   labelled pixels, then streams one record per non-empty label.
//   Ports:
//     clk, reset            clock, synchronous active-high reset
//     en                    pixel valid; hsync/vsync/label sampled when high
//     hsync, vsync          first pixel of row / frame
//     frame_end             one-cycle pulse after the last pixel of a frame
//     label                 labelled pixel (low LABEL_W bits used)
//     stat_valid/ready      record handshake
//     stat_label, stat_min_x/max_x/min_y/max_y, stat_count, stat_last
//     busy                  high while dumping or clearing
//     overrun               sticky: pixel arrived while busy
// -----------------------------------------------------------------------------
module blob_stats
  import blob_stats_pkg::*;
#(
  parameter int LABEL_W = LABEL_W_DEF,
  parameter int COORD_W = COORD_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  hsync,
  input  logic                  vsync,
  input  logic                  frame_end,
  input  logic [PIXEL_SIZE-1:0] label,
  output logic                  stat_valid,
  input  logic                  stat_ready,
  output logic [LABEL_W-1:0]    stat_label,
  output logic [COORD_W-1:0]    stat_min_x,
  output logic [COORD_W-1:0]    stat_max_x,
  output logic [COORD_W-1:0]    stat_min_y,
  output logic [COORD_W-1:0]    stat_max_y,
  output logic [CNT_W-1:0]      stat_count,
  output logic                  stat_last,
  output logic                  busy,
  output logic                  overrun
);

  state_e             state_q, state_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [LABEL_W-1:0] clr_idx_q, clr_idx_d;
  logic [LABEL_W-1:0] scan_q, scan_d;
  // Highest label hit this frame: entries never empty within a frame, so
  // this is also the label that carries stat_last.
  logic [LABEL_W-1:0] max_label_q, max_label_d;
  logic               done_q, done_d;       // last record already loaded
  logic               overrun_q, overrun_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;
  logic [LABEL_W-1:0] rec_label_q, rec_label_d;
  logic [COORD_W-1:0] rec_min_x_q, rec_min_x_d, rec_max_x_q, rec_max_x_d;
  logic [COORD_W-1:0] rec_min_y_q, rec_min_y_d, rec_max_y_q, rec_max_y_d;
  logic [CNT_W-1:0]   rec_cnt_q, rec_cnt_d;

  logic [LABEL_W-1:0] lbl;
  logic [LABEL_W-1:0] tbl_raddr;
  logic [CNT_W-1:0]   rd_cnt;
  logic [COORD_W-1:0] rd_min_x, rd_max_x, rd_min_y, rd_max_y;
  logic               tbl_we, tbl_clr;
  logic [CNT_W-1:0]   wr_cnt;
  logic [COORD_W-1:0] wr_min_x, wr_max_x, wr_min_y, wr_max_y;
  logic               slot_free;

  assign lbl = label[LABEL_W-1:0];

  blob_stats_table #(
    .LABEL_W (LABEL_W),
    .COORD_W (COORD_W),
    .CNT_W   (CNT_W)
  ) u_table (
    .clk        (clk),
    .raddr_i    (tbl_raddr),
    .rd_cnt_o   (rd_cnt),
    .rd_min_x_o (rd_min_x),
    .rd_max_x_o (rd_max_x),
    .rd_min_y_o (rd_min_y),
    .rd_max_y_o (rd_max_y),
    .we_i       (tbl_we),
    .waddr_i    (lbl),
    .wr_cnt_i   (wr_cnt),
    .wr_min_x_i (wr_min_x),
    .wr_max_x_i (wr_max_x),
    .wr_min_y_i (wr_min_y),
    .wr_max_y_i (wr_max_y),
    .clr_i      (tbl_clr),
    .caddr_i    (clr_idx_q)
  );

  // Coordinate tracker; the pixel is tagged with the updated position.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (en) begin
      if (vsync) begin
        x_d = '0;
        y_d = '0;
      end else if (hsync) begin
        x_d = '0;
        y_d = y_q + COORD_W'(1);
      end else begin
        x_d = x_q + COORD_W'(1);
      end
    end
  end

  // Entry update for the current pixel: first hit loads the coordinate,
  // later hits widen the box and bump the saturating count.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    wr_cnt   = rd_cnt;
    wr_min_x = rd_min_x;
    wr_max_x = rd_max_x;
    wr_min_y = rd_min_y;
    wr_max_y = rd_max_y;
    if (rd_cnt == '0) begin
      wr_cnt   = CNT_W'(1);
      wr_min_x = x_d;
      wr_max_x = x_d;
      wr_min_y = y_d;
      wr_max_y = y_d;
    end else begin
      wr_cnt = (&rd_cnt) ? rd_cnt : rd_cnt + CNT_W'(1);
      if (x_d < rd_min_x) wr_min_x = x_d;
      if (x_d > rd_max_x) wr_max_x = x_d;
      if (y_d < rd_min_y) wr_min_y = y_d;
      if (y_d > rd_max_y) wr_max_y = y_d;
    end
  end

  // Controller next-state and table control.
  always_comb begin
    state_d     = state_q;
    clr_idx_d   = clr_idx_q;
    scan_d      = scan_q;
    max_label_d = max_label_q;
    done_d      = done_q;
    overrun_d   = overrun_q;
    valid_d     = valid_q;
    last_d      = last_q;
    rec_label_d = rec_label_q;
    rec_min_x_d = rec_min_x_q;
    rec_max_x_d = rec_max_x_q;
    rec_min_y_d = rec_min_y_q;
    rec_max_y_d = rec_max_y_q;
    rec_cnt_d   = rec_cnt_q;
    tbl_raddr   = lbl;
    tbl_we      = 1'b0;
    tbl_clr     = 1'b0;
    slot_free   = 1'b0;

    if (en && (state_q != ST_ACCUM)) overrun_d = 1'b1;

    case (state_q)
      ST_CLEAR: begin
        tbl_clr   = 1'b1;
        clr_idx_d = clr_idx_q + LABEL_W'(1);
        if (&clr_idx_q) state_d = ST_ACCUM;
      end

      ST_ACCUM: begin
        if (en && (lbl != '0)) begin
          tbl_we = 1'b1;
          if (lbl > max_label_q) max_label_d = lbl;
        end
        // A pixel on the frame_end cycle is written above before the switch.
        if (frame_end) begin
          state_d = ST_DUMP;
          scan_d  = LABEL_W'(1);
          done_d  = 1'b0;
        end
      end

      ST_DUMP: begin
        tbl_raddr = scan_q;
        if (valid_q && stat_ready) begin
          valid_d = 1'b0;
          if (last_q) begin
            state_d     = ST_CLEAR;
            clr_idx_d   = '0;
            max_label_d = '0;
          end
        end
        // Load the next record only when the output register is empty or
        // draining this cycle, so a held record never changes under valid.
        slot_free = !valid_q || stat_ready;
        if (slot_free && !done_q) begin
          if (max_label_q == '0) begin
            valid_d     = 1'b1;
            last_d      = 1'b1;
            done_d      = 1'b1;
            rec_label_d = '0;
            rec_min_x_d = '0;
            rec_max_x_d = '0;
            rec_min_y_d = '0;
            rec_max_y_d = '0;
            rec_cnt_d   = '0;
          end else begin
            scan_d = scan_q + LABEL_W'(1);
            if (rd_cnt != '0) begin
              valid_d     = 1'b1;
              last_d      = (scan_q == max_label_q);
              done_d      = (scan_q == max_label_q);
              rec_label_d = scan_q;
              rec_min_x_d = rd_min_x;
              rec_max_x_d = rd_max_x;
              rec_min_y_d = rd_min_y;
              rec_max_y_d = rd_max_y;
              rec_cnt_d   = rd_cnt;
            end
          end
        end
      end

      default: state_d = ST_CLEAR;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_CLEAR;
      x_q         <= '0;
      y_q         <= '0;
      clr_idx_q   <= '0;
      scan_q      <= '0;
      max_label_q <= '0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      rec_label_q <= '0;
      rec_min_x_q <= '0;
      rec_max_x_q <= '0;
      rec_min_y_q <= '0;
      rec_max_y_q <= '0;
      rec_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      clr_idx_q   <= clr_idx_d;
      scan_q      <= scan_d;
      max_label_q <= max_label_d;
      done_q      <= done_d;
      overrun_q   <= overrun_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      rec_label_q <= rec_label_d;
      rec_min_x_q <= rec_min_x_d;
      rec_max_x_q <= rec_max_x_d;
      rec_min_y_q <= rec_min_y_d;
      rec_max_y_q <= rec_max_y_d;
      rec_cnt_q   <= rec_cnt_d;
    end
  end

  assign stat_valid = valid_q;
  assign stat_last  = last_q;
  assign stat_label = rec_label_q;
  assign stat_min_x = rec_min_x_q;
  assign stat_max_x = rec_max_x_q;
  assign stat_min_y = rec_min_y_q;
  assign stat_max_y = rec_max_y_q;
  assign stat_count = rec_cnt_q;
  assign busy       = (state_q != ST_ACCUM);
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_blob_stats.sv
// -----------------------------------------------------------------------------
// tb_blob_stats
//   Directed frames for blob_stats; expected records are pushed to a
//   scoreboard queue and a monitor compares them at each handshake.
// -----------------------------------------------------------------------------
module tb_blob_stats;
  import blob_stats_pkg::*;

  logic        clk = 1'b0;
  logic        reset, en, hsync, vsync, frame_end, stat_ready;
  logic [7:0]  label;
  logic        stat_valid, stat_last, busy, overrun;
  logic [7:0]  stat_label;
  logic [11:0] stat_min_x, stat_max_x, stat_min_y, stat_max_y;
  logic [19:0] stat_count;

  always #5 clk = ~clk;

  blob_stats dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .hsync      (hsync),
    .vsync      (vsync),
    .frame_end  (frame_end),
    .label      (label),
    .stat_valid (stat_valid),
    .stat_ready (stat_ready),
    .stat_label (stat_label),
    .stat_min_x (stat_min_x),
    .stat_max_x (stat_max_x),
    .stat_min_y (stat_min_y),
    .stat_max_y (stat_max_y),
    .stat_count (stat_count),
    .stat_last  (stat_last),
    .busy       (busy),
    .overrun    (overrun)
  );

  int        n_checks = 0;
  int        n_pass   = 0;
  blob_rec_t exp_q[$];
  logic [7:0] pix [0:7][0:7];

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int l, input int x0, input int x1, input int y0,
                      input int y1, input int cnt, input bit last);
    blob_rec_t r;
    r.label = 8'(l);
    r.min_x = 12'(x0);
    r.max_x = 12'(x1);
    r.min_y = 12'(y0);
    r.max_y = 12'(y1);
    r.count = 20'(cnt);
    r.last  = last;
    exp_q.push_back(r);
  endtask

  task automatic clear_map();
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) pix[y][x] = 8'd0;
  endtask

  task automatic run_frame(input int w, input int h, input bit fe_on_last);
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        en    = 1'b1;
        vsync = (x == 0) && (y == 0);
        hsync = (x == 0);
        label = pix[y][x];
        if (fe_on_last && (y == h - 1) && (x == w - 1)) frame_end = 1'b1;
        tick();
      end
    end
    en    = 1'b0;
    hsync = 1'b0;
    vsync = 1'b0;
    label = 8'd0;
    if (!fe_on_last) begin
      frame_end = 1'b1;
      tick();
    end
    frame_end = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 2000) begin
      tick();
      n++;
    end
    check({"idle_timeout_", name}, busy, 0);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!stat_valid && n < 1000) begin
      tick();
      n++;
    end
    check({"valid_timeout_", name}, stat_valid, 1);
  endtask

  // Scoreboard monitor: a record transfers on the next posedge whenever
  // valid and ready are both high at the preceding negedge.
  initial begin
    blob_rec_t got;
    blob_rec_t want;
    forever begin
      @(negedge clk);
      if (!reset && stat_valid && stat_ready) begin
        got.label = stat_label;
        got.min_x = stat_min_x;
        got.max_x = stat_max_x;
        got.min_y = stat_min_y;
        got.max_y = stat_max_y;
        got.count = stat_count;
        got.last  = stat_last;
        check("record_expected", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          want = exp_q.pop_front();
          check("record", got, want);
        end
      end
    end
  end

  initial begin
    int  n;
    bit  any_valid;

    reset = 1'b1; en = 1'b0; hsync = 1'b0; vsync = 1'b0;
    frame_end = 1'b0; label = 8'd0; stat_ready = 1'b1;
    clear_map();
    repeat (3) tick();

    // Reset state.
    check("rst_valid",   stat_valid, 0);
    check("rst_last",    stat_last,  0);
    check("rst_overrun", overrun,    0);
    check("rst_busy",    busy,       1);
    check("rst_fields",  {stat_label, stat_min_x, stat_max_x, stat_min_y,
                          stat_max_y, stat_count}, 0);

    // Clear sweep after reset lasts one cycle per entry.
    reset = 1'b0;
    n = 0;
    any_valid = 1'b0;
    while (busy && n < 1000) begin
      if (stat_valid) any_valid = 1'b1;
      n++;
      tick();
    end
    check("clear_cycles", n, 256);
    check("clear_no_valid", any_valid, 0);

    // Single blob, frame_end after the last pixel.
    pix[0][1] = 8'd5; pix[0][2] = 8'd5; pix[1][1] = 8'd5;
    push(5, 1, 2, 0, 1, 3, 1'b1);
    run_frame(4, 3, 1'b0);
    wait_idle("single");

    // Two blobs with backpressure: first record must hold still.
    clear_map();
    pix[0][0] = 8'd3; pix[2][3] = 8'd7;
    push(3, 0, 0, 0, 0, 1, 1'b0);
    push(7, 3, 3, 2, 2, 1, 1'b1);
    stat_ready = 1'b0;
    run_frame(4, 3, 1'b0);
    wait_valid("hold");
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", stat_valid, 1);
      check("hold_label", stat_label, 3);
      check("hold_last",  stat_last,  0);
      tick();
    end
    stat_ready = 1'b1;
    wait_idle("hold");

    // Empty frame gives the single all-zero last record.
    clear_map();
    push(0, 0, 0, 0, 0, 0, 1'b1);
    run_frame(4, 3, 1'b0);
    wait_idle("empty");

    // Back-to-back same label, two labels, frame_end on the last pixel.
    clear_map();
    pix[0][0] = 8'd2; pix[0][1] = 8'd2; pix[0][2] = 8'd2;
    pix[1][1] = 8'd9; pix[1][2] = 8'd2; pix[1][3] = 8'd9;
    push(2, 0, 2, 0, 1, 4, 1'b0);
    push(9, 1, 3, 1, 1, 2, 1'b1);
    run_frame(4, 2, 1'b1);
    wait_idle("b2b");
    check("overrun_clean", overrun, 0);

    // Pixel during dump sets sticky overrun and leaves the record intact.
    clear_map();
    pix[0][1] = 8'd5; pix[0][2] = 8'd5; pix[1][1] = 8'd5;
    push(5, 1, 2, 0, 1, 3, 1'b1);
    stat_ready = 1'b0;
    run_frame(4, 3, 1'b0);
    wait_valid("overrun");
    en = 1'b1; label = 8'd5;
    tick();
    en = 1'b0; label = 8'd0;
    check("overrun_set", overrun, 1);
    stat_ready = 1'b1;
    wait_idle("overrun");
    clear_map();
    pix[1][2] = 8'd4;
    push(4, 2, 2, 1, 1, 1, 1'b1);
    run_frame(4, 3, 1'b0);
    wait_idle("overrun_next");
    check("overrun_sticky", overrun, 1);

    // Reset mid-dump: no further records, no stale entries afterwards.
    clear_map();
    pix[0][0] = 8'd4; pix[0][1] = 8'd6;
    push(4, 0, 0, 0, 0, 1, 1'b0);
    stat_ready = 1'b0;
    run_frame(4, 3, 1'b0);
    wait_valid("abort");
    stat_ready = 1'b1;
    tick();
    stat_ready = 1'b0;
    reset = 1'b1;
    tick();
    check("abort_valid", stat_valid, 0);
    check("abort_overrun", overrun, 0);
    reset = 1'b0;
    stat_ready = 1'b1;
    wait_idle("abort_clear");
    clear_map();
    pix[1][2] = 8'd1;
    push(1, 2, 2, 1, 1, 1, 1'b1);
    run_frame(4, 3, 1'b0);
    wait_idle("after_abort");

    repeat (4) tick();
    check("sb_leftover", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/blob_stats.md
BLOB_STATS -- requirements
Module: blob_stats

Interface
REQ-001 Parameters SHALL be: LABEL_W, default 8, label bits used (label[LABEL_W-1:0]); COORD_W, default 12, x/y coordinate width; CNT_W, default 20, pixel-count width.
REQ-002 clk  in  1  single clock; all logic on posedge clk.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 en  in  1  pixel-valid qualifier; label/hsync/vsync sampled only when en=1.
REQ-005 hsync  in  1  high with the first pixel of each row.
REQ-006 vsync  in  1  high with the first pixel of each frame.
REQ-007 frame_end  in  1  one-cycle pulse after the last pixel of a frame.
REQ-008 label  in  `PIXEL_SIZE  labelled pixel from the labelling stage; only low LABEL_W bits used.
REQ-009 stat_valid / stat_ready  out / in  1 each  record handshake; transfer when both high.
REQ-010 stat_label  out  LABEL_W  label of current record.
REQ-011 stat_min_x, stat_max_x, stat_min_y, stat_max_y  out  COORD_W each  bounding box.
REQ-012 stat_count  out  CNT_W  pixels carrying that label.
REQ-013 stat_last  out  1  high with the final record of a frame.
REQ-014 busy  out  1  high in DUMP or CLEAR.
REQ-015 overrun  out  1  sticky: pixel arrived while busy.

Function
REQ-016 States SHALL be ACCUM, DUMP, CLEAR; reset enters CLEAR.
REQ-017 Coordinates SHALL be tracked per accepted pixel: vsync -> x=0,y=0; hsync without vsync -> x=0,y=y+1; otherwise x=x+1; the pixel is tagged with the updated coordinate.
REQ-018 In ACCUM, each accepted pixel with label!=0 SHALL update its entry in the same cycle: count+1 (saturating at all-ones), min/max x/y widened; first hit (count==0) loads min=max=coordinate.
REQ-019 Back-to-back pixels with the same label SHALL both be counted (no read-modify-write hazard; 1-cycle update).
REQ-020 Label 0 SHALL be ignored (background).
REQ-021 frame_end in ACCUM SHALL move to DUMP next cycle; a pixel on the same cycle as frame_end SHALL be accumulated first.
REQ-022 DUMP SHALL scan labels 1..2^LABEL_W-1 ascending, presenting only entries with count!=0, at most one record per cycle when stat_ready=1.
REQ-023 stat_valid SHALL hold with stable record fields until accepted; stat_valid SHALL NOT depend combinationally on stat_ready.
REQ-024 stat_last SHALL mark the highest non-empty label; if no entries are non-empty, one record with stat_label=0, all fields 0, stat_last=1 SHALL be emitted.
REQ-025 After the stat_last transfer, state SHALL go to CLEAR, zeroing all entries at one per cycle (2^LABEL_W cycles), then ACCUM.
REQ-026 Accepted pixels during DUMP/CLEAR SHALL be dropped and set overrun; overrun clears only on reset.
REQ-027 frame_end outside ACCUM SHALL be ignored.

Reset
REQ-028 On reset: stat_valid=0, stat_last=0, stat_* fields=0, overrun=0, busy=1, x=y=0, state=CLEAR with clear index 0.
REQ-029 Reset mid-DUMP SHALL abort the dump with no further records; the table is then cleared.

Structure
REQ-030 Default widths, state enum and the record struct SHALL live in a shared package alongside global.vh definitions.
REQ-031 The entry table SHALL be one sub-module, blob_stats_table (register array, 1 combinational read port, 1 write port, clear port).

Verification
REQ-032 After reset, no stimulus -> busy=1 for 256 cycles, then 0; stat_valid stays 0.
REQ-033 4x3 frame, label 5 at (1,0),(2,0),(1,1) -> one record: label 5, x 1..2, y 0..1, count 3, last=1.
REQ-034 Labels 3 at (0,0) and 7 at (3,2), stat_ready held low 5 cycles -> label 3 held stable, then 3 then 7, last only on 7.
REQ-035 All-zero frame then frame_end -> single record label 0, count 0, last=1.
REQ-036 Pixel with en=1 during DUMP -> overrun=1, remains 1 through next frame; record contents unchanged.
REQ-037 Reset asserted after first record accepted -> stat_valid=0 next cycle; subsequent frame shows no stale entries.
